// File: rtl/fpmult_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// fpmult_rr_scheduler_if
//   Bundles the requester, FPMult and response signals of the shared-multiplier
//   scheduler. clk and rst are not part of the bundle.
//
//   Signals:
//     req_valid / req_ready   per-requester handshake (ready is one-hot or zero)
//     req_a / req_b           packed operands, requester i at [i*DWIDTH +: DWIDTH]
//     mult_a / mult_b         registered operands into FPMult
//     mult_result/mult_flags  FPMult product and exception flags
//     rsp_valid / rsp_ready   result FIFO head handshake
//     rsp_id/result/flags     head entry (zero while the FIFO is empty)
//     busy                    operation in flight or FIFO non-empty
//
//   Modports:
//     slave   the scheduler
//     master  the environment (requesters, FPMult, result consumer)
// ----------------------------------------------------------------------------
interface fpmult_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DWIDTH  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DWIDTH-1:0] req_a;
  logic [NUM_REQ*DWIDTH-1:0] req_b;
  logic [DWIDTH-1:0]         mult_a;
  logic [DWIDTH-1:0]         mult_b;
  logic [DWIDTH-1:0]         mult_result;
  logic [4:0]                mult_flags;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DWIDTH-1:0]         rsp_result;
  logic [4:0]                rsp_flags;
  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, mult_result, mult_flags, rsp_ready,
    output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );

  modport master (
    output req_valid, req_a, req_b, mult_result, mult_flags, rsp_ready,
    input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );
endinterface

// File: rtl/fpmult_rr_scheduler.sv
// ----------------------------------------------------------------------------
// fpmult_rr_scheduler
//   Shares one pipelined half-precision FPMult among NUM_REQ requesters.
//   A round-robin arbiter issues at most one operand pair per cycle into
//   registered mult_a/mult_b, a tag pipe carries each requester ID alongside
//   the multiplier, and retiring results are written into a first-word-fall-
//   through FIFO. Issue is credit-limited so a retiring result always finds
//   room in the FIFO.
//
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   fpmult_rr_scheduler_if.slave (requesters, FPMult, response, busy)
// ----------------------------------------------------------------------------
module fpmult_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int DWIDTH       = 16,
  parameter int MULT_LATENCY = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fpmult_rr_scheduler_if.slave bus
);

  localparam int IDX_W = ID_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for fifo_count + inflight without overflow.
  localparam int CNT_W = $clog2(FIFO_DEPTH + MULT_LATENCY + 1);
  localparam int ENT_W = ID_W + DWIDTH + 5;

  localparam logic [IDX_W-1:0] NUM_REQ_C = IDX_W'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DWIDTH-1:0] mult_a_q, mult_a_d;
  logic [DWIDTH-1:0] mult_b_q, mult_b_d;
  logic [MULT_LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]   tag_id_q [MULT_LATENCY];
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Credit check and round-robin arbitration
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]     credit_used;
  logic                 can_issue;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_off;
  logic [IDX_W-1:0]     grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic                 issue;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic [DWIDTH-1:0]    sel_a, sel_b;

  assign credit_used = fifo_count_q + inflight_q;
  assign can_issue   = (credit_used < DEPTH_C);

  // Rotate the valids so bit 0 is the requester at ptr; the lowest set bit of
  // the rotated vector is then the round-robin winner.
  assign req_dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    grant_valid = 1'b0;
    grant_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        grant_off   = IDX_W'(k);
      end
    end
  end

  assign grant_sum = {1'b0, ptr_q} + grant_off;
  assign grant_idx = (grant_sum >= NUM_REQ_C) ? ID_W'(grant_sum - NUM_REQ_C)
                                              : ID_W'(grant_sum);
  // A grant only exists on a valid request, so issue is the transfer.
  assign issue = can_issue & grant_valid;

  always_comb begin
    req_ready_c = '0;
    if (issue) begin
      req_ready_c[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[i*DWIDTH +: DWIDTH];
        sel_b = bus.req_b[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    mult_a_d = '0;
    mult_b_d = '0;
    if (issue) begin
      mult_a_d = sel_a;
      mult_b_d = sel_b;
      ptr_d    = (grant_idx == LAST_REQ) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe. Stage 0 is loaded on the same edge as mult_a/mult_b, so the last
  // stage is valid in exactly the cycle the matching product is presented.
  // --------------------------------------------------------------------------
  logic retire;
  assign retire = tag_vld_q[MULT_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
      end
    end
  end

  // IDs need no reset; they are only consumed when the matching valid is set.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_idx;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  always_comb begin
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + ONE_C;
      2'b01:   inflight_d = inflight_q - ONE_C;
      default: inflight_d = inflight_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic push, pop, fifo_empty;
  logic [ENT_W-1:0] head;

  assign push       = retire;
  assign fifo_empty = (fifo_count_q == '0);
  assign pop        = ~fifo_empty & bus.rsp_ready;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + ONE_C;
      2'b01:   fifo_count_d = fifo_count_q - ONE_C;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {tag_id_q[MULT_LATENCY-1], bus.mult_result, bus.mult_flags};
    end
  end

  // --------------------------------------------------------------------------
  // Registers with reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_count_q == DEPTH_C)));

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = req_ready_c;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.rsp_valid  = ~fifo_empty;
  assign bus.rsp_id     = fifo_empty ? '0 : head[ENT_W-1 -: ID_W];
  assign bus.rsp_result = fifo_empty ? '0 : head[DWIDTH+4:5];
  assign bus.rsp_flags  = fifo_empty ? '0 : head[4:0];
  assign bus.busy       = (inflight_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fpmult_rr_scheduler
//   Directed bench for fpmult_rr_scheduler. A small behavioural FPMult model
//   treats the mult_a/mult_b register as its first stage, so a product appears
//   MULT_LATENCY-1 cycles after the operands show on mult_a/mult_b.
//   Inputs change at the falling edge; outputs are sampled 2 time units later.
// ----------------------------------------------------------------------------
module tb_fpmult_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DWIDTH  = 16;
  localparam int LAT     = 5;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fpmult_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DWIDTH(DWIDTH)) bus ();

  fpmult_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DWIDTH(DWIDTH),
    .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Truncating fp16 multiply for normal operands; flag bit 0 marks inexact.
  function automatic logic [20:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [9:0]  m;
    logic        inex;
    int          e;
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {5'd0, a[15] ^ b[15], 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11]; inex = |p[10:0]; e = e + 1;
    end else begin
      m = p[19:10]; inex = |p[9:0];
    end
    return {4'd0, inex, a[15] ^ b[15], e[4:0], m};
  endfunction

  logic [15:0] pa [LAT-1];
  logic [15:0] pb [LAT-1];
  logic [20:0] prod;

  always @(posedge clk) begin
    pa[0] <= bus.mult_a;
    pb[0] <= bus.mult_b;
    for (int k = 1; k < LAT - 1; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end

  assign prod            = fmul(pa[LAT-2], pb[LAT-2]);
  assign bus.mult_result = prod[15:0];
  assign bus.mult_flags  = prod[20:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*DWIDTH +: DWIDTH] = a;
    bus.req_b[i*DWIDTH +: DWIDTH] = b;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mult_a"},     32'(bus.mult_a),     32'h0);
    chk({tag, "_mult_b"},     32'(bus.mult_b),     32'h0);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'h0);
    chk({tag, "_busy"},       32'(bus.busy),       32'h0);
    chk({tag, "_rsp_id"},     32'(bus.rsp_id),     32'h0);
    chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'h0);
    chk({tag, "_rsp_flags"},  32'(bus.rsp_flags),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected product / flags per requester in the backpressure and skip tests.
  logic [15:0] res_by_id [4];
  logic [4:0]  flg_by_id [4];
  logic [3:0]  exp_ready;
  logic        exp_valid;
  int          exp_id;
  int          cnt;

  initial begin
    res_by_id[0] = 16'h4000; res_by_id[1] = 16'h4400;
    res_by_id[2] = 16'h4800; res_by_id[3] = 16'h3C02;
    flg_by_id[0] = 5'd0; flg_by_id[1] = 5'd0;
    flg_by_id[2] = 5'd0; flg_by_id[3] = 5'd1;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #2;
    chk_idle_outputs("reset");
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;

    // ---------------- single request ----------------
    @(negedge clk);
    set_ops(2, 16'h4000, 16'h4200);
    bus.req_valid = 4'b0100;
    #2;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    #2;
    chk("single_ready_off", 32'(bus.req_ready), 32'h0);
    chk("single_mult_a", 32'(bus.mult_a), 32'h4000);
    chk("single_mult_b", 32'(bus.mult_b), 32'h4200);
    chk("single_busy", 32'(bus.busy), 32'h1);
    cnt = 1;
    while (!bus.rsp_valid && cnt < 20) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    chk("single_latency", 32'(cnt), 32'(LAT + 1));
    chk("single_rsp_id", 32'(bus.rsp_id), 32'h2);
    chk("single_rsp_result", 32'(bus.rsp_result), 32'h4600);
    chk("single_rsp_flags", 32'(bus.rsp_flags), 32'h0);
    chk("single_idle_mult_a", 32'(bus.mult_a), 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("single_drained_valid", 32'(bus.rsp_valid), 32'h0);
    chk("single_drained_busy", 32'(bus.busy), 32'h0);

    // ---------------- round robin, all requesters ----------------
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 16'h3E00, 16'h4000);
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      bus.req_valid = (j < 12) ? 4'hF : 4'h0;
      #2;
      exp_ready = '0;
      if (j < 12) exp_ready[j % 4] = 1'b1;
      exp_valid = (j >= 6) && (j < 18);
      chk($sformatf("rr_ready_c%0d", j), 32'(bus.req_ready), 32'(exp_ready));
      chk($sformatf("rr_rsp_valid_c%0d", j), 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk($sformatf("rr_rsp_id_c%0d", j), 32'(bus.rsp_id), 32'((j - 6) % 4));
        chk($sformatf("rr_rsp_result_c%0d", j), 32'(bus.rsp_result), 32'h4200);
      end
    end

    // ------- backpressure / credit limit, then push+pop at depth 7 -------
    set_ops(0, 16'h3C00, 16'h4000);
    set_ops(1, 16'h3C00, 16'h4400);
    set_ops(2, 16'h3C00, 16'h4800);
    set_ops(3, 16'h3C01, 16'h3C01);
    for (int j = 0; j <= 28; j++) begin
      @(negedge clk);
      bus.req_valid = (j <= 15) ? 4'hF : 4'h0;
      bus.rsp_ready = (j == 14) || (j >= 20);
      #2;
      exp_ready = '0;
      if (j < 8) exp_ready[j % 4] = 1'b1;
      if (j == 15) exp_ready[0] = 1'b1;
      exp_valid = (j >= 6) && (j <= 27);
      exp_id = (j <= 14) ? 0 : (j <= 19) ? 1 : (j - 19) % 4;
      chk($sformatf("bp_ready_c%0d", j), 32'(bus.req_ready), 32'(exp_ready));
      chk($sformatf("bp_rsp_valid_c%0d", j), 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk($sformatf("bp_rsp_id_c%0d", j), 32'(bus.rsp_id), 32'(exp_id));
        chk($sformatf("bp_rsp_result_c%0d", j), 32'(bus.rsp_result), 32'(res_by_id[exp_id]));
        chk($sformatf("bp_rsp_flags_c%0d", j), 32'(bus.rsp_flags), 32'(flg_by_id[exp_id]));
      end
      if (j == 16) chk("bp_busy_mid", 32'(bus.busy), 32'h1);
      if (j == 28) chk("bp_busy_end", 32'(bus.busy), 32'h0);
    end

    // ---------------- pointer skip (1 and 3 only) ----------------
    bus.rsp_ready = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      bus.req_valid = (j == 0) ? 4'b0010 : (j <= 3) ? 4'b1010 : 4'b0000;
      #2;
      exp_ready = (j == 0 || j == 2) ? 4'b0010 : (j == 1 || j == 3) ? 4'b1000 : 4'b0000;
      exp_valid = (j >= 6) && (j <= 9);
      exp_id = (j % 2 == 0) ? 1 : 3;
      chk($sformatf("skip_ready_c%0d", j), 32'(bus.req_ready), 32'(exp_ready));
      chk($sformatf("skip_rsp_valid_c%0d", j), 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk($sformatf("skip_rsp_id_c%0d", j), 32'(bus.rsp_id), 32'(exp_id));
        chk($sformatf("skip_rsp_result_c%0d", j), 32'(bus.rsp_result), 32'(res_by_id[exp_id]));
      end
    end

    // ---------------- reset mid-operation ----------------
    bus.rsp_ready = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      bus.req_valid = (j <= 4 || j == 16) ? 4'hF : 4'h0;
      #2;
      if (j <= 4) begin
        exp_ready = '0;
        exp_ready[j % 4] = 1'b1;
        chk($sformatf("rstmid_ready_c%0d", j), 32'(bus.req_ready), 32'(exp_ready));
      end
      if (j == 7) begin
        chk("rstmid_pre_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rstmid_pre_busy", 32'(bus.busy), 32'h1);
        chk("rstmid_pre_id", 32'(bus.rsp_id), 32'h0);
        rst = 1'b1;
      end
      if (j == 8) begin
        chk_idle_outputs("rstmid_post");
        rst = 1'b0;
      end
      if (j >= 9 && j <= 15) begin
        chk($sformatf("rstmid_no_rsp_c%0d", j), 32'(bus.rsp_valid), 32'h0);
        chk($sformatf("rstmid_no_busy_c%0d", j), 32'(bus.busy), 32'h0);
      end
      if (j == 16) chk("rstmid_ptr_reset", 32'(bus.req_ready), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpmult_rr_scheduler.md
Name: fpmult_rr_scheduler

Overview:
Shares one pipelined half-precision FPMult instance among NUM_REQ requesters. Each cycle it selects at most one requesting operand pair by round-robin and drives it into the multiplier. It tracks each issued operation's requester ID through a shift register matched to the multiplier latency. Results are captured into an output FIFO, and issue is throttled by credits so that no in-flight result is ever lost to a full FIFO.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; equals clog2(NUM_REQ)
DWIDTH, 16, floating-point word width (1 sign, 5 exponent, 10 mantissa)
MULT_LATENCY, 5, cycles from operands held on mult_a/mult_b to the matching mult_result
FIFO_DEPTH, 8, result FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*DWIDTH  operand A; requester i in bits [i*DWIDTH +: DWIDTH]
req_b  in  NUM_REQ*DWIDTH  operand B; same packing as req_a
mult_a  out  DWIDTH  registered operand A to FPMult
mult_b  out  DWIDTH  registered operand B to FPMult
mult_result  in  DWIDTH  FPMult result
mult_flags  in  5  FPMult exception flags
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer accept
rsp_id  out  ID_W  requester ID of the head result
rsp_result  out  DWIDTH  head product
rsp_flags  out  5  head flags
busy  out  1  high if any operation is in flight or the FIFO is non-empty

Behaviour:
- Reset is rst, synchronous and active-high; clock is clk.
- On reset: mult_a = 0, mult_b = 0, rsp_valid = 0, busy = 0, round-robin pointer = 0, all tag-pipe valids = 0, FIFO empty, inflight = 0. rsp_id, rsp_result and rsp_flags read 0 while the FIFO is empty.
- Reset mid-operation discards all in-flight tags and FIFO contents. Multiplier results that arrive after reset are ignored because their tags are cleared.
- Credit check: can_issue = (fifo_count + inflight) < FIFO_DEPTH, using registered counts.
- Arbitration (combinational): if can_issue, grant the first i with req_valid[i] set, scanning from ptr upward with wrap-around modulo NUM_REQ. req_ready = onehot(grant), otherwise 0.
- A transfer occurs on req_valid[i] & req_ready[i]. On that edge:
  - mult_a/mult_b <= the granted requester's operands.
  - tag stage 0 <= {valid = 1, id = i}.
  - ptr <= (i + 1) mod NUM_REQ.
- With no transfer: mult_a/mult_b <= 0, tag stage 0 valid <= 0, and ptr holds.
- Tag pipe: MULT_LATENCY stages shifting every cycle, with no stall, because FPMult has no enable. When the last stage is valid in cycle t, mult_result/mult_flags in cycle t belong to that tag. They are written to the FIFO together with the tag's id.
- inflight counts valid tag stages: +1 on issue, −1 on retire, unchanged when both occur in the same cycle.
- FIFO: a push occurs on retire; a pop occurs on rsp_valid & rsp_ready. Simultaneous push and pop keeps the count unchanged. The credit rule guarantees a push never meets a full FIFO; an assertion flags any violation.
- A pop frees credit from the next cycle only, since the counts are registered.
- rsp_* is driven from the FIFO head (first-word-fall-through); rsp_valid = (fifo_count != 0).
- Ordering: results leave in issue order. Per-requester order is therefore preserved.
- Latency: operands accepted at edge E appear on rsp_* at the earliest in cycle E + MULT_LATENCY + 1 (one FIFO write cycle).
- Throughput: one issue per cycle while credits allow and rsp_ready is held high.
- Fairness: a continuously requesting requester waits at most NUM_REQ−1 grants.

Test Plan:
- Single request: requester 2 sends a = 0x4000 (2.0), b = 0x4200 (3.0), then goes idle -> req_ready[2] = 1 for one cycle; rsp_valid rises exactly MULT_LATENCY + 1 cycles later with rsp_id = 2, rsp_result = 0x4600, rsp_flags = 0; busy then falls.
- All four requesters valid continuously with rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, 1, …; one issue per cycle; rsp_id follows the same sequence; requester i uses a = 0x3E00 (1.5), b = 0x4000 (2.0) -> every rsp_result = 0x4200.
- rsp_ready held at 0 with all requesters valid -> exactly 8 issues, then req_ready = 0 while fifo_count = 8 and inflight = 0; release rsp_ready for a single cycle -> one pop, and the next issue occurs one cycle later.
- Pointer skip: only requesters 1 and 3 valid, ptr = 2 -> grant 3, then 1, then 3; requesters 0 and 2 are never granted.
- Reset asserted while 3 operations are in flight and the FIFO holds 2 entries -> all outputs return to their reset values the next cycle; no rsp_valid appears for the dropped operations over the following MULT_LATENCY + 2 cycles.
- Simultaneous push and pop with the FIFO at depth 7 -> count stays 7; FIFO data and rsp_id order stay intact.
